// File: rtl/pic_pkg.sv
// Shared picture geometry and loader FSM states, used by the loader and by
// the draw stage's address generator.
package pic_pkg;

    localparam int H_PIX      = 320;
    localparam int V_PIX      = 240;
    localparam int PIC_PIXELS = H_PIX * V_PIX;
    localparam int AW         = 17;
    localparam int DW         = 24;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

endpackage

// File: rtl/pic_loader.sv
// Frame-buffer writer: streams one RGB picture into the back bank of the
// ping-pong picture RAM and swaps banks when the display side allows it.
module pic_loader #(
    parameter int H_PIX = pic_pkg::H_PIX,
    parameter int V_PIX = pic_pkg::V_PIX,
    parameter int AW    = pic_pkg::AW,
    parameter int DW    = pic_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    input  logic          s_sof,
    output logic          s_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          wr_bank,
    output logic          switch_ram,
    output logic          pic_done,
    input  logic          frame_sw_ram,
    output logic          frame_err,
    output logic [7:0]    frame_cnt
);

    localparam int            PIC_PIXELS = H_PIX * V_PIX;
    localparam logic [AW-1:0] LAST_ADDR  = AW'(PIC_PIXELS - 1);

    pic_pkg::state_t state, state_nxt;
    logic [AW-1:0]   pix_cnt, pix_cnt_nxt;
    logic [AW-1:0]   addr_nxt;
    logic            beat;
    logic            do_write;
    logic            restart;
    logic            swap;

    assign beat     = s_valid && s_ready;
    assign pic_done = (state == pic_pkg::DONE);
    assign wr_bank  = ~switch_ram;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        pix_cnt_nxt = pix_cnt;
        addr_nxt    = pix_cnt;
        do_write    = 1'b0;
        restart     = 1'b0;
        swap        = 1'b0;
        case (state)
            pic_pkg::IDLE: begin
                // Anything before the first start-of-frame is dropped.
                if (beat && s_sof) begin
                    do_write    = 1'b1;
                    addr_nxt    = '0;
                    pix_cnt_nxt = AW'(1);
                    state_nxt   = (LAST_ADDR == '0) ? pic_pkg::DONE : pic_pkg::FILL;
                end
            end
            pic_pkg::FILL: begin
                if (beat) begin
                    do_write = 1'b1;
                    if (s_sof) begin
                        // Early start-of-frame wins even on the last address.
                        restart     = 1'b1;
                        addr_nxt    = '0;
                        pix_cnt_nxt = AW'(1);
                    end else if (pix_cnt == LAST_ADDR) begin
                        pix_cnt_nxt = '0;
                        state_nxt   = pic_pkg::DONE;
                    end else begin
                        pix_cnt_nxt = pix_cnt + AW'(1);
                    end
                end
            end
            pic_pkg::DONE: begin
                if (frame_sw_ram) begin
                    swap      = 1'b1;
                    state_nxt = pic_pkg::IDLE;
                end
            end
            default: state_nxt = pic_pkg::IDLE;
        endcase
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // the sensitivity list holds only the clock; state uses non-blocking <=.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= pic_pkg::IDLE;
            pix_cnt    <= '0;
            s_ready    <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            switch_ram <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= 8'd0;
        end else begin
            state     <= state_nxt;
            pix_cnt   <= pix_cnt_nxt;
            // Registered ready: it falls the cycle after the last beat.
            s_ready   <= (state_nxt != pic_pkg::DONE);
            wr_en     <= do_write;
            frame_err <= restart;
            if (do_write) begin
                wr_addr <= addr_nxt;
                wr_data <= s_data;
            end
            if (swap) begin
                switch_ram <= ~switch_ram;
                frame_cnt  <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pic_loader.sv
// Self-checking bench for pic_loader: directed and random pixel streams
// compared cycle by cycle against a picture-position reference model.
module tb_pic_loader;

    // A small picture keeps the run short; the loader depends only on the pixel count.
    localparam int TH   = 40;
    localparam int TV   = 30;
    localparam int NPIX = TH * TV;
    localparam int TAW  = pic_pkg::AW;
    localparam int TDW  = pic_pkg::DW;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [TDW-1:0] s_data;
    logic           s_valid;
    logic           s_sof;
    logic           s_ready;
    logic           wr_en;
    logic [TAW-1:0] wr_addr;
    logic [TDW-1:0] wr_data;
    logic           wr_bank;
    logic           switch_ram;
    logic           pic_done;
    logic           frame_sw_ram;
    logic           frame_err;
    logic [7:0]     frame_cnt;

    pic_loader #(.H_PIX(TH), .V_PIX(TV), .AW(TAW), .DW(TDW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_sof        (s_sof),
        .s_ready      (s_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_bank      (wr_bank),
        .switch_ram   (switch_ram),
        .pic_done     (pic_done),
        .frame_sw_ram (frame_sw_ram),
        .frame_err    (frame_err),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: position inside the picture (-1 = waiting for a
    // start-of-frame), whether a complete picture awaits its swap, bank, swaps.
    int             m_pos;
    bit             m_done;
    bit             m_sw;
    int             m_cnt;
    bit             m_ready;
    bit             m_we;
    bit             m_err;
    int             m_addr;
    logic [TDW-1:0] m_data;

    int n_checks = 0;
    int n_fail   = 0;
    int n_wr     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("wr_en", 32'(wr_en), 32'(m_we));
        if (m_we) begin
            check("wr_addr", 32'(wr_addr), 32'(m_addr));
            check("wr_data", 32'(wr_data), 32'(m_data));
        end
        check("frame_err",  32'(frame_err),  32'(m_err));
        check("pic_done",   32'(pic_done),   32'(m_done));
        check("switch_ram", 32'(switch_ram), 32'(m_sw));
        check("wr_bank",    32'(wr_bank),    32'(!m_sw));
        check("frame_cnt",  32'(frame_cnt),  32'(m_cnt));
        check("s_ready",    32'(s_ready),    32'(m_ready));
    endtask

    // Drive one cycle of inputs, advance the model by the same rules, then
    // compare every output shortly after the clock edge.
    task automatic step(input bit rst, input bit v, input bit sof,
                        input logic [TDW-1:0] d, input bit sw);
        rst_n        = rst;
        s_valid      = v;
        s_sof        = sof;
        s_data       = d;
        frame_sw_ram = sw;
        m_we  = 1'b0;
        m_err = 1'b0;
        if (!rst) begin
            m_pos   = -1;
            m_done  = 1'b0;
            m_sw    = 1'b0;
            m_cnt   = 0;
            m_ready = 1'b0;
            m_addr  = 0;
            m_data  = '0;
        end else begin
            if (m_done) begin
                if (sw) begin
                    m_sw   = !m_sw;
                    m_cnt  = (m_cnt + 1) % 256;
                    m_done = 1'b0;
                end
            end else if (v && m_ready) begin
                if (sof) begin
                    m_err  = (m_pos >= 0);
                    m_we   = 1'b1;
                    m_addr = 0;
                    m_data = d;
                    m_pos  = 1;
                end else if (m_pos >= 0) begin
                    m_we   = 1'b1;
                    m_addr = m_pos;
                    m_data = d;
                    m_pos  = m_pos + 1;
                end
                if (m_pos == NPIX) begin
                    m_done = 1'b1;
                    m_pos  = -1;
                end
            end
            m_ready = !m_done;
        end
        @(posedge clk);
        #1;
        check_outputs();
        if (wr_en) n_wr++;
    endtask

    initial begin
        rst_n        = 1'b0;
        s_valid      = 1'b0;
        s_sof        = 1'b0;
        s_data       = '0;
        frame_sw_ram = 1'b0;
        m_pos = -1; m_done = 0; m_sw = 0; m_cnt = 0; m_ready = 0;
        m_addr = 0; m_data = '0; m_we = 0; m_err = 0;

        // Reset values, including s_ready low while reset is held.
        step(1'b0, 1'b1, 1'b1, 24'h123456, 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);

        // Full picture, data = address; swap request on the last beat is ignored.
        for (int i = 0; i < NPIX; i++)
            step(1'b1, 1'b1, (i == 0), 24'(i), (i == NPIX - 1));
        check("full_pic_done", 32'(pic_done), 32'd1);
        // Wait in DONE with valid held high; swap on the tenth cycle.
        for (int i = 0; i < 9; i++)
            step(1'b1, 1'b1, 1'b0, 24'hABCDEF, 1'b0);
        step(1'b1, 1'b1, 1'b0, 24'hABCDEF, 1'b1);
        check("swap_switch_ram", 32'(switch_ram), 32'd1);
        check("swap_frame_cnt",  32'(frame_cnt),  32'd1);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);

        // Pre-sof garbage, then 100 beats, then an early restart.
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 1'b0, 24'($urandom), 1'b0);
        for (int i = 0; i < 100; i++)
            step(1'b1, 1'b1, (i == 0), 24'($urandom), 1'b0);
        for (int i = 0; i < NPIX; i++)
            step(1'b1, 1'b1, (i == 0), 24'($urandom), (i == 500));
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        check("restart_frame_cnt", 32'(frame_cnt), 32'd2);

        // Random bubbles on s_valid: the write count must equal one picture.
        n_wr = 0;
        step(1'b1, 1'b1, 1'b1, 24'($urandom), 1'b0);
        for (int i = 0; i < 10 * NPIX && !m_done; i++)
            step(1'b1, 1'($urandom_range(1, 0)), 1'b0, 24'($urandom), 1'b0);
        check("bp_pic_done", 32'(pic_done), 32'd1);
        check("bp_write_count", 32'(n_wr), 32'(NPIX));
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);

        // Start-of-frame on the last address restarts instead of completing.
        for (int i = 0; i < NPIX; i++)
            step(1'b1, 1'b1, (i == 0 || i == NPIX - 1), 24'($urandom), 1'b0);
        check("last_sof_no_done", 32'(pic_done), 32'd0);
        for (int i = 0; i < NPIX / 2 - 1; i++)
            step(1'b1, 1'b1, 1'b0, 24'($urandom), 1'b0);

        // Reset mid-picture after three swaps, then a fresh picture from address 0.
        step(1'b0, 1'b1, 1'b0, 24'($urandom), 1'b0);
        check("rst_switch_ram", 32'(switch_ram), 32'd0);
        step(1'b1, 1'b1, 1'b0, 24'($urandom), 1'b0);
        for (int i = 0; i < NPIX; i++)
            step(1'b1, 1'b1, (i == 0), 24'($urandom), 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        check("final_frame_cnt", 32'(frame_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
